// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game: sequences the datapath counters and
// registers, and reports the game outcome and current state.
module unidade_controle_jogo #(
    parameter bit HAS_TIMEOUT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fim_jogo,
    input  logic       timeout,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic       zera_limite,
    output logic       conta_limite,
    output logic       zeraR,
    output logic       registrarR,
    output logic       zera_s_timeout,
    output logic       enable_timeout,
    output logic       zera_modo,
    output logic       registra_modo,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_ERROU      = 4'hB,
        FIM_TIMEOUT    = 4'hC
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; unused codes fall back to INICIAL.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIA_RODADA;
            INICIA_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play arriving together with timeout is still accepted.
                if (jogada_feita) begin
                    estado_d = REGISTRA;
                end else if (timeout && HAS_TIMEOUT) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA_JOGADA;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERROU;
                end else if (enderecoIgualLimite && fim_jogo) begin
                    estado_d = FIM_ACERTOU;
                end else if (enderecoIgualLimite) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:        estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_ACERTOU:    estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        estado_d = INICIAL;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        zera_endereco  = 1'b0;
        conta_endereco = 1'b0;
        zera_limite    = 1'b0;
        conta_limite   = 1'b0;
        zeraR          = 1'b0;
        registrarR     = 1'b0;
        zera_s_timeout = 1'b0;
        enable_timeout = 1'b0;
        zera_modo      = 1'b0;
        registra_modo  = 1'b0;
        pronto         = 1'b0;
        ganhou         = 1'b0;
        perdeu         = 1'b0;
        db_timeout     = 1'b0;
        case (estado_q)
            INICIAL: begin
                zera_modo = 1'b1;
            end
            PREPARACAO: begin
                zera_endereco  = 1'b1;
                zera_limite    = 1'b1;
                zeraR          = 1'b1;
                zera_s_timeout = 1'b1;
                registra_modo  = 1'b1;
            end
            INICIA_RODADA: begin
                zera_endereco  = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ESPERA_JOGADA: begin
                enable_timeout = 1'b1;
            end
            REGISTRA: begin
                registrarR     = 1'b1;
                zera_s_timeout = 1'b1;
            end
            PROXIMO: begin
                conta_endereco = 1'b1;
            end
            PROXIMA_RODADA: begin
                conta_limite = 1'b1;
            end
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule
